imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader upstream of the instruction memory.
- Accepts a byte stream through a valid/ready handshake and assembles little-endian 32-bit words.
- Issues single-cycle word writes into instruction memory.
- Holds the processor core in reset until the image is fully loaded. Only after that may the core fetch from PC = BASE_ADDR.

Parameters:
- DEPTH_WORDS, 1024, instruction memory capacity in 32-bit words; upper bound on image length.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- byteValid  input  1  byteData is valid this cycle
- byteData  input  8  incoming stream byte
- byteReady  output  1  loader accepts a byte this cycle
- imemWriteEnable  output  1  one-cycle instruction memory write strobe
- imemWriteAddr  output  32  byte address of the word being written
- imemWriteData  output  32  assembled instruction word
- coreHold  output  1  held high to keep the core in reset; drives the core's rst together with the system rst
- loadDone  output  1  image loaded successfully (sticky)
- loadError  output  1  image rejected (sticky)

Behaviour:
- Single clock; reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - byteReady=0, imemWriteEnable=0, imemWriteAddr=BASE_ADDR, imemWriteData=0
  - coreHold=1, loadDone=0, loadError=0
  - internal counters=0, state=RECV_LEN
- Handshake:
  - A byte transfers on a rising edge where byteValid && byteReady.
  - byteData is ignored when no transfer occurs.
  - byteReady is high only in RECV_LEN, RECV_DATA and RECV_SUM; it is 0 in all other states.
- Stream format: 4-byte word count N (LE), then N words of 4 bytes each (LE, first byte = bits [7:0]), then an optional checksum (see Optional Feature).
- A 2-bit byte counter tracks the byte lane and wraps 3 -> 0 on the 4th accepted byte.
- States:
  - RECV_LEN: collect 4 bytes into N.
    - On the 4th byte: if N > DEPTH_WORDS go to ERROR; else if N == 0 go to FINISH; else go to RECV_DATA.
  - RECV_DATA: collect 4 bytes into the word register. On the 4th byte go to WRITE.
  - WRITE: exactly one cycle.
    - imemWriteEnable=1, imemWriteAddr = BASE_ADDR + 4*wordIdx, imemWriteData = assembled word.
    - wordIdx increments.
    - If wordIdx+1 == N go to FINISH; else go to RECV_DATA.
    - No byte is accepted in this cycle.
  - FINISH: go to RECV_SUM if the feature is enabled; otherwise go to DONE. No byte is accepted.
  - RECV_SUM: collect 4 checksum bytes, then compare (see Optional Feature).
  - DONE: coreHold=0, loadDone=1. Terminal until rst.
  - ERROR: coreHold=1, loadError=1. Terminal until rst.
- Latency: imemWriteEnable asserts exactly 1 cycle after the edge that accepts a word's 4th byte.
- Peak throughput: 4 bytes per 5 cycles.
- Arithmetic:
  - wordIdx is clog2(DEPTH_WORDS)+1 bits wide and never exceeds N.
  - Address arithmetic is 32-bit modulo 2^32.
- Boundaries:
  - N == DEPTH_WORDS: accepted; the last write goes to BASE_ADDR + 4*(DEPTH_WORDS-1).
  - N == DEPTH_WORDS+1: ERROR, and no write occurs.
  - byteValid held high continuously: no byte is lost or duplicated across WRITE cycles.
  - Idle gaps: there is no timeout; partial words persist indefinitely.
  - Bytes offered in DONE or ERROR are never accepted.
- Reset mid-load (any state): all state clears on the next edge.
  - Already-written memory words are not erased.
  - The next accepted byte is treated as N[7:0].
- loadDone and loadError are never both 1.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - A 32-bit accumulator sums every written word, modulo 2^32, updated in WRITE.
  - After the last word (or directly after N == 0), 4 LE checksum bytes are received in RECV_SUM.
  - Equal to the accumulator: go to DONE. Unequal: go to ERROR.
  - Memory contents already written are left in place.
- Undefined:
  - No RECV_SUM state and no accumulator.
  - FINISH goes straight to DONE.
  - Trailing bytes are never accepted.

Test Plan:
- Reset, then stream 02 00 00 00, 13 00 00 00, B3 00 21 00 with byteValid held high -> two writes: (addr 0x0, data 0x00000013) and (addr 0x4, data 0x002100B3), one cycle each, 5 cycles apart. Then loadDone=1 and coreHold=0.
- N=0 (00 00 00 00) -> no imemWriteEnable pulse; DONE on the cycle after FINISH (feature off).
- N=DEPTH_WORDS+1 (01 04 00 00 with default depth) -> loadError=1, coreHold=1, byteReady=0, zero writes.
- Random byteValid gaps (50% duty) with N=3 -> same three write address/data pairs as the gap-free run; no duplicated or dropped bytes.
- Assert rst after 6 bytes of an N=2 image, then resend the full image -> writes restart at BASE_ADDR with correct data; final loadDone=1.
- With IMEM_LOADER_CHECKSUM_EN defined: N=1, word 0x00000013:
  - checksum bytes 13 00 00 00 -> loadDone=1.
  - checksum bytes 14 00 00 00 -> loadError=1, coreHold stays 1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | imem_loader : boot-time byte-stream loader into instruction memory; holds   |
// |   the core in reset until the image is in. Option: IMEM_LOADER_CHECKSUM_EN  |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module imem_loader #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byteValid,
  input  logic [7:0]  byteData,
  output logic        byteReady,
  output logic        imemWriteEnable,
  output logic [31:0] imemWriteAddr,
  output logic [31:0] imemWriteData,
  output logic        coreHold,
  output logic        loadDone,
  output logic        loadError
);

  localparam int               IDX_W   = $clog2(DEPTH_WORDS) + 1;
  localparam logic [IDX_W-1:0] IDX_ONE = 1;

  typedef enum logic [2:0] {
    RECV_LEN  = 3'd0,
    RECV_DATA = 3'd1,
    WRITE     = 3'd2,
    FINISH    = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    RECV_SUM  = 3'd4,
`endif
    DONE      = 3'd5,
    ERROR     = 3'd6
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [1:0]       byte_cnt;
  logic [31:0]      len_q;
  logic [31:0]      word_q;
  logic [IDX_W-1:0] word_idx;
  logic             recv_state;
  logic             accept;
  logic             last_byte;
  logic [31:0]      len_full;
  logic [31:0]      word_full;
  logic [31:0]      idx_ext;
  logic [31:0]      idx_plus1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      accum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign recv_state = (state == RECV_LEN) || (state == RECV_DATA) || (state == RECV_SUM);
`else
  assign recv_state = (state == RECV_LEN) || (state == RECV_DATA);
`endif

  // Gated by rst so the handshake is quiet while reset is held.
  assign byteReady = recv_state && !rst;
  assign accept    = byteValid && byteReady;
  assign last_byte = accept && (byte_cnt == 2'd3);

  // Bytes shift in from the top, so the first byte ends up in bits [7:0].
  assign len_full  = {byteData, len_q[31:8]};
  assign word_full = {byteData, word_q[31:8]};

  assign idx_ext       = 32'(word_idx);
  assign idx_plus1     = idx_ext + 32'd1;
  assign imemWriteAddr = BASE_ADDR + {idx_ext[29:0], 2'b00};
  assign imemWriteData = word_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RECV_LEN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    imemWriteEnable = 1'b0;
    coreHold        = 1'b1;
    loadDone        = 1'b0;
    loadError       = 1'b0;
    case (state)
      RECV_LEN: begin
        if (last_byte) begin
          if (len_full > 32'(DEPTH_WORDS)) begin
            state_next = ERROR;
          end else if (len_full == 32'd0) begin
            state_next = FINISH;
          end else begin
            state_next = RECV_DATA;
          end
        end
      end
      RECV_DATA: begin
        if (last_byte) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        imemWriteEnable = 1'b1;
        state_next      = (idx_plus1 == len_q) ? FINISH : RECV_DATA;
      end
      FINISH: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        state_next = RECV_SUM;
`else
        state_next = DONE;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      RECV_SUM: begin
        if (last_byte) begin
          state_next = (word_full == accum) ? DONE : ERROR;
        end
      end
`endif
      DONE: begin
        coreHold = 1'b0;
        loadDone = 1'b1;
      end
      ERROR: begin
        loadError = 1'b1;
      end
      default: begin
        state_next = ERROR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt <= 2'd0;
      len_q    <= 32'd0;
      word_q   <= 32'd0;
      word_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      accum    <= 32'd0;
`endif
    end else begin
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        if (state == RECV_LEN) begin
          len_q <= len_full;
        end else begin
          // Data words and the trailing checksum share the assembly register.
          word_q <= word_full;
        end
      end
      if (state == WRITE) begin
        word_idx <= word_idx + IDX_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        accum    <= accum + word_q;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_imem_loader : self-checking bench for imem_loader                        |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

  localparam int          DEPTH  = 1024;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          BUDGET = 20000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        byteValid = 1'b0;
  logic [7:0]  byteData = 8'h00;
  logic        byteReady;
  logic        imemWriteEnable;
  logic [31:0] imemWriteAddr;
  logic [31:0] imemWriteData;
  logic        coreHold;
  logic        loadDone;
  logic        loadError;

  imem_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .byteValid(byteValid), .byteData(byteData),
    .byteReady(byteReady), .imemWriteEnable(imemWriteEnable),
    .imemWriteAddr(imemWriteAddr), .imemWriteData(imemWriteData),
    .coreHold(coreHold), .loadDone(loadDone), .loadError(loadError)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: everything observed on the memory port, cleared while in reset.
  logic [31:0] got_addr[$];
  logic [31:0] got_data[$];
  int          got_cyc[$];
  int          done_cyc = -1;
  int          both_err = 0;
  always @(negedge clk) begin
    if (rst) begin
      got_addr.delete(); got_data.delete(); got_cyc.delete();
      done_cyc = -1;
    end else begin
      if (imemWriteEnable) begin
        got_addr.push_back(imemWriteAddr);
        got_data.push_back(imemWriteData);
        got_cyc.push_back(cyc);
      end
      if (loadDone && done_cyc < 0) done_cyc = cyc;
    end
    if (loadDone && loadError) both_err++;
  end

  // Reference model output: byte stream plus the expected write list.
  logic [7:0]  tx[$];
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  int          acc_cyc[$];
  int          extra_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_word(input logic [31:0] w);
    tx.push_back(w[7:0]);  tx.push_back(w[15:8]);
    tx.push_back(w[23:16]); tx.push_back(w[31:24]);
  endtask

  task automatic build_stream(input logic [31:0] len);
    logic [31:0] w;
    logic [31:0] sum;
    tx.delete(); exp_addr.delete(); exp_data.delete();
    sum = 32'd0;
    push_word(len);
    if (len <= 32'(DEPTH)) begin
      for (int i = 0; i < int'(len); i++) begin
        w = $urandom;
        push_word(w);
        exp_addr.push_back(BASE + 32'(i) * 32'd4);
        exp_data.push_back(w);
        sum = sum + w;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      push_word(sum);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; byteValid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; offers tx bytes with the given valid duty (percent).
  task automatic run_stream(input int duty);
    int idx = 0;
    int n   = 0;
    bit acc;
    acc_cyc.delete();
    while (idx < tx.size() && n < BUDGET) begin
      byteValid = ($urandom_range(0, 99) < duty);
      byteData  = byteValid ? tx[idx] : 8'($urandom);
      #1;
      acc = byteValid && byteReady;
      if (acc) acc_cyc.push_back(cyc);
      @(posedge clk);
      if (acc) idx++;
      @(negedge clk);
      n++;
    end
    byteValid = 1'b0;
    chk("stream_timeout", 32'(n >= BUDGET), 32'd0);
  endtask

  // Keeps offering junk bytes until a terminal flag, then counts any readiness.
  task automatic wait_terminal();
    int n = 0;
    extra_ready = 0;
    byteValid = 1'b1;
    byteData  = 8'($urandom);
    #1;
    while (!(loadDone || loadError) && n < BUDGET) begin
      @(negedge clk);
      byteData = 8'($urandom);
      #1;
      n++;
    end
    chk("terminal_timeout", 32'(n >= BUDGET), 32'd0);
    repeat (4) begin
      @(negedge clk);
      byteData = 8'($urandom);
      #1;
      if (byteReady) extra_ready++;
    end
    byteValid = 1'b0;
  endtask

  task automatic cmp_writes(input string tag);
    chk({tag, "_nwrites"}, got_addr.size(), exp_addr.size());
    for (int j = 0; j < got_addr.size() && j < exp_addr.size(); j++) begin
      chk($sformatf("%s_addr%0d", tag, j), got_addr[j], exp_addr[j]);
      chk($sformatf("%s_data%0d", tag, j), got_data[j], exp_data[j]);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ready"}, byteReady, 32'd0);
    chk({tag, "_wen"},   imemWriteEnable, 32'd0);
    chk({tag, "_addr"},  imemWriteAddr, BASE);
    chk({tag, "_data"},  imemWriteData, 32'd0);
    chk({tag, "_hold"},  coreHold, 32'd1);
    chk({tag, "_done"},  loadDone, 32'd0);
    chk({tag, "_err"},   loadError, 32'd0);
  endtask

  typedef struct {
    logic [31:0] len;
    int          duty;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t        vecs[7];
    logic [7:0]  full_tx[$];

    vecs[0] = '{32'd0,           100, 0,    1'b1, 1'b0};
    vecs[1] = '{32'd1025,        100, 0,    1'b0, 1'b1};
    vecs[2] = '{32'd3,           50,  3,    1'b1, 1'b0};
    vecs[3] = '{32'd1,           100, 1,    1'b1, 1'b0};
    vecs[4] = '{32'h0001_0000,   70,  0,    1'b0, 1'b1};
    vecs[5] = '{32'd1024,        100, 1024, 1'b1, 1'b0};
    vecs[6] = '{32'd5,           30,  5,    1'b1, 1'b0};

    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("rst0");
    rst = 1'b0;

    // Two-word image, gap-free: 5-cycle write spacing, 1-cycle latency.
    tx.delete(); exp_addr.delete(); exp_data.delete();
    push_word(32'd2); push_word(32'h0000_0013); push_word(32'h0021_00B3);
`ifdef IMEM_LOADER_CHECKSUM_EN
    push_word(32'h0021_00C6);
`endif
    exp_addr.push_back(32'h0); exp_data.push_back(32'h0000_0013);
    exp_addr.push_back(32'h4); exp_data.push_back(32'h0021_00B3);
    run_stream(100);
    wait_terminal();
    cmp_writes("two");
    if (got_cyc.size() == 2 && acc_cyc.size() >= 12) begin
      chk("two_latency", got_cyc[0], acc_cyc[7] + 1);
      chk("two_spacing", got_cyc[1] - got_cyc[0], 32'd5);
    end
    chk("two_done", loadDone, 32'd1);
    chk("two_hold", coreHold, 32'd0);
    chk("two_err",  loadError, 32'd0);
    chk("two_ready_term", extra_ready, 32'd0);

    do_reset();
    #1;
    chk("rst_from_done_hold", coreHold, 32'd1);
    chk("rst_from_done_done", loadDone, 32'd0);

`ifndef IMEM_LOADER_CHECKSUM_EN
    // Empty image: DONE two cycles after the 4th length byte (via FINISH).
    tx.delete();
    push_word(32'd0);
    run_stream(100);
    wait_terminal();
    chk("empty_nwrites", got_addr.size(), 32'd0);
    if (acc_cyc.size() == 4) chk("empty_done_cyc", done_cyc, acc_cyc[3] + 2);
    do_reset();
`endif

    for (int i = 0; i < 7; i++) begin
      do_reset();
      build_stream(vecs[i].len);
      run_stream(vecs[i].duty);
      wait_terminal();
      chk($sformatf("v%0d_nwrites_tbl", i), got_addr.size(), vecs[i].exp_writes);
      cmp_writes($sformatf("v%0d", i));
      chk($sformatf("v%0d_done", i), loadDone, vecs[i].exp_done);
      chk($sformatf("v%0d_err", i), loadError, vecs[i].exp_err);
      chk($sformatf("v%0d_hold", i), coreHold, !vecs[i].exp_done);
      chk($sformatf("v%0d_ready_term", i), extra_ready, 32'd0);
    end

    // Reset after 6 bytes of a two-word image, then resend the whole image.
    do_reset();
    build_stream(32'd2);
    full_tx = tx;
    tx = full_tx[0:5];
    run_stream(100);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals("midrst");
    rst = 1'b0;
    @(negedge clk);
    tx = full_tx;
    run_stream(100);
    wait_terminal();
    cmp_writes("midrst");
    chk("midrst_done", loadDone, 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    do_reset();
    tx.delete(); exp_addr.delete(); exp_data.delete();
    push_word(32'd1); push_word(32'h13); push_word(32'h13);
    exp_addr.push_back(BASE); exp_data.push_back(32'h13);
    run_stream(100);
    wait_terminal();
    cmp_writes("sum_ok");
    chk("sum_ok_done", loadDone, 32'd1);
    chk("sum_ok_err",  loadError, 32'd0);

    do_reset();
    tx.delete();
    push_word(32'd1); push_word(32'h13); push_word(32'h14);
    run_stream(100);
    wait_terminal();
    cmp_writes("sum_bad");
    chk("sum_bad_err",  loadError, 32'd1);
    chk("sum_bad_done", loadDone, 32'd0);
    chk("sum_bad_hold", coreHold, 32'd1);
`endif

    chk("flags_exclusive", both_err, 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
